ex_wb_scheduler: RTL and testbench

//  Sequences the 5-stage multiplier (EX1..EX5) pipeline and arbitrates the single register-file

---
 rtl/params_pkg.sv | 22 ++
 rtl/wb_skid_buf.sv | 45 ++++
 rtl/ex_wb_scheduler.sv | 168 ++++++++++++++++
 tb/tb_ex_wb_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared widths and record types for the EX/WB scheduling slice.
package params_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int REGISTER_WIDTH = 5;
    localparam int EX_STAGES      = 5;

    // One multiplier pipeline slot: occupancy, destination and PC for debug.
    typedef struct packed {
        logic                      valid;
        logic [REGISTER_WIDTH-1:0] rd;
        logic [ADDR_WIDTH-1:0]     pc;
    } ex_stage_t;

    // A pending register-file write.
    typedef struct packed {
        logic [REGISTER_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry holding buffer for an ALU/load write that lost arbitration to EX5.
// A pop and a push in the same cycle replace the entry.
module wb_skid_buf
    import params_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wb_req_t push_req_i,
    input  logic    pop_i,
    output logic    full_o,
    output wb_req_t req_o
);

    logic    full_q, full_d;
    wb_req_t req_q, req_d;

    // Next entry state: pop clears, push (possibly on top of a pop) loads.
    always_comb begin
        full_d = full_q;
        req_d  = req_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            full_d = 1'b1;
            req_d  = push_req_i;
        end
    end

    // Entry register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign full_o = full_q;
    assign req_o  = req_q;

endmodule

// File: rtl/ex_wb_scheduler.sv
// Tracks muls through the fixed-depth multiplier pipeline and arbitrates the
// single register-file write port: EX5 first, then the skid entry, then a live
// ALU/load request. The write port outputs are registered.
module ex_wb_scheduler
    import params_pkg::*;
#(
    parameter int DATA_WIDTH_P     = DATA_WIDTH,
    parameter int ADDR_WIDTH_P     = ADDR_WIDTH,
    parameter int REGISTER_WIDTH_P = REGISTER_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        freeze_i,
    input  logic                        ex_issue_valid_i,
    input  logic [REGISTER_WIDTH_P-1:0] ex_issue_rd_i,
    input  logic [ADDR_WIDTH_P-1:0]     ex_issue_pc_i,
    input  logic [DATA_WIDTH_P-1:0]     mul_result_i,
    input  logic                        alu_wb_valid_i,
    input  logic [REGISTER_WIDTH_P-1:0] alu_wb_rd_i,
    input  logic [DATA_WIDTH_P-1:0]     alu_wb_data_i,
    output logic                        alu_wb_ready_o,
    output logic [EX_STAGES-1:0]        ex_stage_en_o,
    output logic                        ex1_valid_o,
    output logic                        ex2_valid_o,
    output logic                        ex3_valid_o,
    output logic                        ex4_valid_o,
    output logic                        ex5_valid_o,
    output logic [REGISTER_WIDTH_P-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH_P-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH_P-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH_P-1:0] ex4_wr_reg_o,
    output logic [REGISTER_WIDTH_P-1:0] ex5_wr_reg_o,
    output logic [ADDR_WIDTH_P-1:0]     ex5_pc_o,
    output logic                        wb_is_next_cycle_o,
    output logic                        wb_reg_wr_en_o,
    output logic [REGISTER_WIDTH_P-1:0] wb_wr_reg_o,
    output logic [DATA_WIDTH_P-1:0]     wb_data_to_reg_o
);

    ex_stage_t ex_q [EX_STAGES];
    ex_stage_t ex_d [EX_STAGES];

    logic                        wb_en_q,   wb_en_d;
    logic [REGISTER_WIDTH_P-1:0] wb_reg_q,  wb_reg_d;
    logic [DATA_WIDTH_P-1:0]     wb_data_q, wb_data_d;

    logic    ex5_v;
    logic    skid_full, skid_push, skid_pop;
    wb_req_t skid_req, alu_req;

    // Pipeline shift: no inter-stage stall, only freeze holds everything.
    // Idle slots carry zero rd/pc so decode never sees stale destinations.
    always_comb begin
        for (int i = 0; i < EX_STAGES; i++) begin
            ex_d[i] = ex_q[i];
        end
        if (!freeze_i) begin
            ex_d[0].valid = ex_issue_valid_i;
            ex_d[0].rd    = ex_issue_valid_i ? ex_issue_rd_i : '0;
            ex_d[0].pc    = ex_issue_valid_i ? ex_issue_pc_i : '0;
            for (int i = 1; i < EX_STAGES; i++) begin
                ex_d[i] = ex_q[i-1];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < EX_STAGES; i++) begin
                ex_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < EX_STAGES; i++) begin
                ex_q[i] <= ex_d[i];
            end
        end
    end

    // Datapath clock enables: a stage loads only when its feeder holds a mul.
    always_comb begin
        ex_stage_en_o[0] = !freeze_i && ex_issue_valid_i;
        for (int i = 1; i < EX_STAGES; i++) begin
            ex_stage_en_o[i] = !freeze_i && ex_q[i-1].valid;
        end
    end

    assign ex1_valid_o  = ex_q[0].valid;
    assign ex2_valid_o  = ex_q[1].valid;
    assign ex3_valid_o  = ex_q[2].valid;
    assign ex4_valid_o  = ex_q[3].valid;
    assign ex5_valid_o  = ex_q[4].valid;
    assign ex1_wr_reg_o = ex_q[0].rd;
    assign ex2_wr_reg_o = ex_q[1].rd;
    assign ex3_wr_reg_o = ex_q[2].rd;
    assign ex4_wr_reg_o = ex_q[3].rd;
    assign ex5_wr_reg_o = ex_q[4].rd;
    assign ex5_pc_o     = ex_q[4].pc;

    assign wb_is_next_cycle_o = ex_q[3].valid && !freeze_i;

    // Arbitration handshake: the ALU is turned away only when EX5 owns the
    // port and the skid slot is already taken, or when frozen.
    assign ex5_v          = ex_q[EX_STAGES-1].valid;
    assign alu_wb_ready_o = !freeze_i && (!ex5_v || !skid_full);
    assign skid_push      = alu_wb_valid_i && alu_wb_ready_o && (ex5_v || skid_full);
    assign skid_pop       = !freeze_i && !ex5_v && skid_full;
    assign alu_req        = '{rd: alu_wb_rd_i, data: alu_wb_data_i};

    wb_skid_buf u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (skid_push),
        .push_req_i (alu_req),
        .pop_i      (skid_pop),
        .full_o     (skid_full),
        .req_o      (skid_req)
    );

    // Write-port mux: EX5 > skid > live ALU; writes to x0 are consumed silently.
    always_comb begin
        wb_en_d   = 1'b0;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        if (!freeze_i) begin
            if (ex5_v) begin
                wb_en_d   = |ex_q[EX_STAGES-1].rd;
                wb_reg_d  = ex_q[EX_STAGES-1].rd;
                wb_data_d = mul_result_i;
            end else if (skid_full) begin
                wb_en_d   = |skid_req.rd;
                wb_reg_d  = skid_req.rd;
                wb_data_d = skid_req.data;
            end else if (alu_wb_valid_i) begin
                wb_en_d   = |alu_wb_rd_i;
                wb_reg_d  = alu_wb_rd_i;
                wb_data_d = alu_wb_data_i;
            end
        end
    end

    // Registered write port.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_reg_wr_en_o   = wb_en_q;
    assign wb_wr_reg_o      = wb_reg_q;
    assign wb_data_to_reg_o = wb_data_q;

    // Decode must stall issue while frozen.
    a_no_issue_in_freeze : assert property (@(posedge clk_i) disable iff (!rst_i)
        freeze_i |-> !ex_issue_valid_i);

    // A refused ALU request must be held unchanged.
    a_alu_hold : assert property (@(posedge clk_i) disable iff (!rst_i)
        (alu_wb_valid_i && !alu_wb_ready_o) |=>
            (alu_wb_valid_i && $stable(alu_wb_rd_i) && $stable(alu_wb_data_i)));

endmodule

// File: tb/tb_ex_wb_scheduler.sv
module tb_ex_wb_scheduler;
    import params_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        freeze_i;
    logic        ex_issue_valid_i;
    logic [4:0]  ex_issue_rd_i;
    logic [31:0] ex_issue_pc_i;
    logic [31:0] mul_result_i;
    logic        alu_wb_valid_i;
    logic [4:0]  alu_wb_rd_i;
    logic [31:0] alu_wb_data_i;
    logic        alu_wb_ready_o;
    logic [4:0]  ex_stage_en_o;
    logic        ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o;
    logic [4:0]  ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o, ex5_wr_reg_o;
    logic [31:0] ex5_pc_o;
    logic        wb_is_next_cycle_o;
    logic        wb_reg_wr_en_o;
    logic [4:0]  wb_wr_reg_o;
    logic [31:0] wb_data_to_reg_o;

    always #5 clk_i = ~clk_i;

    ex_wb_scheduler dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .freeze_i           (freeze_i),
        .ex_issue_valid_i   (ex_issue_valid_i),
        .ex_issue_rd_i      (ex_issue_rd_i),
        .ex_issue_pc_i      (ex_issue_pc_i),
        .mul_result_i       (mul_result_i),
        .alu_wb_valid_i     (alu_wb_valid_i),
        .alu_wb_rd_i        (alu_wb_rd_i),
        .alu_wb_data_i      (alu_wb_data_i),
        .alu_wb_ready_o     (alu_wb_ready_o),
        .ex_stage_en_o      (ex_stage_en_o),
        .ex1_valid_o        (ex1_valid_o),
        .ex2_valid_o        (ex2_valid_o),
        .ex3_valid_o        (ex3_valid_o),
        .ex4_valid_o        (ex4_valid_o),
        .ex5_valid_o        (ex5_valid_o),
        .ex1_wr_reg_o       (ex1_wr_reg_o),
        .ex2_wr_reg_o       (ex2_wr_reg_o),
        .ex3_wr_reg_o       (ex3_wr_reg_o),
        .ex4_wr_reg_o       (ex4_wr_reg_o),
        .ex5_wr_reg_o       (ex5_wr_reg_o),
        .ex5_pc_o           (ex5_pc_o),
        .wb_is_next_cycle_o (wb_is_next_cycle_o),
        .wb_reg_wr_en_o     (wb_reg_wr_en_o),
        .wb_wr_reg_o        (wb_wr_reg_o),
        .wb_data_to_reg_o   (wb_data_to_reg_o)
    );

    // Multiplier datapath stand-in: product is a fixed function of the destination.
    function automatic logic [31:0] mul_of(input logic [4:0] rd);
        logic [31:0] k;
        k = {27'd0, rd ^ 5'd5};
        return 32'h1234 ^ (k << 8);
    endfunction

    assign mul_result_i = mul_of(ex5_wr_reg_o);

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        int          wb_off;
        logic        rdy;
        logic        nxt;
        logic [4:0]  v;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic vec_t mk(logic iv, logic [4:0] ird, logic av, logic [4:0] ard,
                                logic [31:0] adata, int wb_off, logic rdy, logic nxt,
                                logic [4:0] v);
        vec_t r;
        r.iv = iv; r.ird = ird; r.av = av; r.ard = ard; r.adata = adata;
        r.wb_off = wb_off; r.rdy = rdy; r.nxt = nxt; r.v = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input int due, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.due = due; e.we = (rd != 5'd0); e.rd = rd; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        freeze_i         = 1'b0;
        ex_issue_valid_i = 1'b0;
        ex_issue_rd_i    = '0;
        ex_issue_pc_i    = '0;
        alu_wb_valid_i   = 1'b0;
        alu_wb_rd_i      = '0;
        alu_wb_data_i    = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] pc);
        ex_issue_valid_i = 1'b1;
        ex_issue_rd_i    = rd;
        ex_issue_pc_i    = pc;
        push_exp(cyc + 6, rd, mul_of(rd));
    endtask

    function automatic logic [31:0] valids();
        return {27'd0, ex5_valid_o, ex4_valid_o, ex3_valid_o, ex2_valid_o, ex1_valid_o};
    endfunction

    initial begin
        int t0;
        rst_i = 1'b0;
        idle_inputs();

        // Write-port scoreboard: every cycle either a due entry or no write.
        fork
            forever begin
                int idx;
                @(negedge clk_i);
                if (chk_en) begin
                    idx = -1;
                    foreach (exp_q[i]) if (exp_q[i].due == cyc) idx = i;
                    if (idx >= 0) begin
                        chk("wb_en", {31'd0, wb_reg_wr_en_o}, {31'd0, exp_q[idx].we});
                        if (exp_q[idx].we) begin
                            chk("wb_rd", {27'd0, wb_wr_reg_o}, {27'd0, exp_q[idx].rd});
                            chk("wb_data", wb_data_to_reg_o, exp_q[idx].data);
                        end
                        exp_q.delete(idx);
                    end else begin
                        chk("wb_idle", {31'd0, wb_reg_wr_en_o}, 32'd0);
                    end
                end
            end
        join_none

        step();
        step();
        chk("rst_valids", valids(), 32'd0);
        chk("rst_wb_en", {31'd0, wb_reg_wr_en_o}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_wr_reg_o}, 32'd0);
        chk("rst_wb_data", wb_data_to_reg_o, 32'd0);
        chk("rst_ex5_pc", ex5_pc_o, 32'd0);
        rst_i  = 1'b1;
        chk_en = 1'b1;
        step();

        //           iv ird  av ard adata        off rdy nxt valids{5..1}
        tbl.push_back(mk(1, 5,  0, 0, 32'h0,       0, 1, 0, 5'b00000)); // r0 single mul
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00001));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00010));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00100));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 1, 5'b01000));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b10000));
        tbl.push_back(mk(1, 1,  0, 0, 32'h0,       0, 1, 0, 5'b00000)); // r6 back-to-back
        tbl.push_back(mk(1, 2,  0, 0, 32'h0,       0, 1, 0, 5'b00001));
        tbl.push_back(mk(1, 3,  0, 0, 32'h0,       0, 1, 0, 5'b00011));
        tbl.push_back(mk(1, 4,  0, 0, 32'h0,       0, 1, 0, 5'b00111));
        tbl.push_back(mk(1, 5,  0, 0, 32'h0,       0, 1, 1, 5'b01111));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 1, 5'b11111));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 1, 5'b11110));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 1, 5'b11100));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 1, 5'b11000));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b10000));
        tbl.push_back(mk(1, 3,  0, 0, 32'h0,       0, 1, 0, 5'b00000)); // r16 collisions
        tbl.push_back(mk(1, 4,  0, 0, 32'h0,       0, 1, 0, 5'b00001));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00011));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00110));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 1, 5'b01100));
        tbl.push_back(mk(0, 0,  1, 7, 32'hAA,      3, 1, 1, 5'b11000)); // into skid
        tbl.push_back(mk(0, 0,  1, 9, 32'hBB,      0, 0, 0, 5'b10000)); // refused
        tbl.push_back(mk(0, 0,  1, 9, 32'hBB,      2, 1, 0, 5'b00000)); // refills skid
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00000));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00000));
        tbl.push_back(mk(1, 0,  1, 0, 32'h55,      1, 1, 0, 5'b00000)); // r26 rd=0 both
        tbl.push_back(mk(0, 0,  1, 12, 32'hC0FFEE, 1, 1, 0, 5'b00001)); // direct ALU
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00010));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00100));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 1, 5'b01000));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b10000));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,       0, 1, 0, 5'b00000));

        foreach (tbl[r]) begin
            idle_inputs();
            if (tbl[r].iv) issue(tbl[r].ird, {25'd0, tbl[r].ird, 2'b00});
            if (tbl[r].av) begin
                alu_wb_valid_i = 1'b1;
                alu_wb_rd_i    = tbl[r].ard;
                alu_wb_data_i  = tbl[r].adata;
                if (tbl[r].wb_off > 0) push_exp(cyc + tbl[r].wb_off, tbl[r].ard, tbl[r].adata);
            end
            #1;
            chk("tbl_ready", {31'd0, alu_wb_ready_o}, {31'd0, tbl[r].rdy});
            chk("tbl_wb_next", {31'd0, wb_is_next_cycle_o}, {31'd0, tbl[r].nxt});
            chk("tbl_valids", valids(), {27'd0, tbl[r].v});
            step();
        end
        idle_inputs();
        step();

        // Freeze for 3 cycles with muls in EX2 and EX4; latency stretches by 3.
        t0 = cyc;
        ex_issue_valid_i = 1'b1; ex_issue_rd_i = 5'd10; ex_issue_pc_i = 32'h100;
        push_exp(t0 + 9, 5'd10, mul_of(5'd10));
        step();
        idle_inputs();
        step();
        ex_issue_valid_i = 1'b1; ex_issue_rd_i = 5'd11; ex_issue_pc_i = 32'h200;
        push_exp(t0 + 11, 5'd11, mul_of(5'd11));
        step();
        idle_inputs();
        #1;
        chk("pre_frz_valids", valids(), 32'b00101);
        chk("pre_frz_en", {27'd0, ex_stage_en_o}, 32'b01010);
        step();
        for (int k = 0; k < 3; k++) begin
            freeze_i       = 1'b1;
            alu_wb_valid_i = 1'b1;
            alu_wb_rd_i    = 5'd20;
            alu_wb_data_i  = 32'h77;
            #1;
            chk("frz_valids", valids(), 32'b01010);
            chk("frz_ex2_rd", {27'd0, ex2_wr_reg_o}, 32'd11);
            chk("frz_ex4_rd", {27'd0, ex4_wr_reg_o}, 32'd10);
            chk("frz_ready", {31'd0, alu_wb_ready_o}, 32'd0);
            chk("frz_wb_next", {31'd0, wb_is_next_cycle_o}, 32'd0);
            chk("frz_en", {27'd0, ex_stage_en_o}, 32'd0);
            step();
        end
        freeze_i = 1'b0;
        #1;
        chk("rel_en", {27'd0, ex_stage_en_o}, 32'b10100);
        chk("rel_ready", {31'd0, alu_wb_ready_o}, 32'd1);
        chk("rel_wb_next", {31'd0, wb_is_next_cycle_o}, 32'd1);
        push_exp(cyc + 1, 5'd20, 32'h77);
        step();
        idle_inputs();
        #1;
        chk("rel_ex5_rd", {27'd0, ex5_wr_reg_o}, 32'd10);
        chk("rel_ex5_pc", ex5_pc_o, 32'h100);
        for (int k = 0; k < 5; k++) step();

        // Async reset with EX3 occupied and the skid slot full.
        t0 = cyc;
        issue(5'd14, 32'h300);
        step();
        idle_inputs();
        step();
        step();
        issue(5'd13, 32'h400);
        step();
        idle_inputs();
        step();
        alu_wb_valid_i = 1'b1; alu_wb_rd_i = 5'd15; alu_wb_data_i = 32'hF0;
        #1;
        chk("rst_pre_ready", {31'd0, alu_wb_ready_o}, 32'd1);
        push_exp(cyc + 2, 5'd15, 32'hF0);
        step();
        idle_inputs();
        #1;
        chk("rst_pre_ex3", {31'd0, ex3_valid_o}, 32'd1);
        #5;
        rst_i = 1'b0;
        #1;
        chk("arst_valids", valids(), 32'd0);
        chk("arst_ex3_rd", {27'd0, ex3_wr_reg_o}, 32'd0);
        chk("arst_wb_en", {31'd0, wb_reg_wr_en_o}, 32'd0);
        chk("arst_wb_rd", {27'd0, wb_wr_reg_o}, 32'd0);
        chk("arst_wb_data", wb_data_to_reg_o, 32'd0);
        exp_q.delete();
        step();
        step();
        #6;
        rst_i = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("post_rst_valids", valids(), 32'd0);

        chk_en = 1'b0;
        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
